rbm_stream_engine: RTL and testbench
====================================

# rbm_stream_engine

Parameterised Avalon-MM control/compute engine for the RBM datapath. It sits between the Qsys Avalon slave port and a memory-reader master. The block:
- Programs the reader's base, length and go signals.
- Consumes the reader's user FIFO through a 2-stage compute pipeline (pass, double or accumulate).
- Buffers results in an internal FIFO that software drains through CSR reads.

## Interface
Parameters:
- DATAWIDTH, 32, width of stream words, results and accumulator
- ADDRESS_WIDTH, 32, width of CSR data, base and length
- RESULT_DEPTH, 16, result FIFO entries; power of two, ≥4

Ports (reset: asynchronous, active-high; clock: clk):
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- avs_s0_address  in  3  CSR word address
- avs_s0_read  in  1  CSR read strobe
- avs_s0_write  in  1  CSR write strobe
- avs_s0_writedata  in  ADDRESS_WIDTH  CSR write data
- avs_s0_readdata  out  ADDRESS_WIDTH  CSR read data; zero-extended or truncated to ADDRESS_WIDTH
- avs_s0_readdatavalid  out  1  read data valid
- coe_control_fixed_location  out  1  tied 0
- coe_control_read_base  out  ADDRESS_WIDTH  BASE register
- coe_control_read_length  out  ADDRESS_WIDTH  LENGTH register, in bytes
- coe_control_go  out  1  one-cycle reader start pulse
- coe_control_done  in  1  reader finished
- coe_control_early_done  in  1  ignored
- coe_user_buffer_data  in  DATAWIDTH  reader FIFO head
- coe_user_data_available  in  1  reader FIFO non-empty
- coe_user_read_buffer  out  1  pop reader FIFO

## Operation
CSR map:
- 0 CONTROL
  - Write: bit0 start; bits[2:1] mode (0 pass, 1 double, 2 accumulate-only, 3 = pass).
  - Read: current mode.
- 1 BASE, read/write.
- 2 LENGTH, read/write.
- 3 STATUS, read-only:
  - bit0 busy
  - bit1 done (sticky)
  - bit2 result FIFO empty
  - bit3 underflow error (sticky)
  - bits[15:8] FIFO fill count
- 4 RESULT: a read pops the FIFO head. If the FIFO is empty, the read returns 0 and sets underflow.
- 5 ACCUM: running sum, read-only.
- 6 WORDCOUNT: words consumed this run, read-only.
- 7: reads 0; writes ignored.

State machine:
- IDLE → LAUNCH on a start write.
  - Start clears done, underflow, ACCUM, WORDCOUNT and the result FIFO.
  - Start latches mode.
  - If LENGTH==0, go to DONE instead of LAUNCH; no go pulse is issued.
- LAUNCH → RUN after one cycle. coe_control_go=1 only in LAUNCH.
- RUN → DRAIN when coe_control_done is sampled high.
- DRAIN → DONE once the reader FIFO is empty (available=0) and the pipeline holds no valid stage.
- DONE → IDLE after one cycle, setting done=1.

Rules while busy (state ≠ IDLE):
- Start writes are ignored.
- BASE and LENGTH writes are ignored.
- CONTROL writes are ignored, including the mode bits.

Pop condition: coe_user_read_buffer = available & (RUN|DRAIN) & (fill + inflight ≤ RESULT_DEPTH−1), where inflight = number of valid pipeline stages. The result FIFO can never overflow.

Pipeline:
- S1 registers the popped word.
- S2 computes the result: pass = x; double = x<<1, truncated to DATAWIDTH.
- On leaving S2: ACCUM += x (modulo 2^DATAWIDTH) in all modes, and WORDCOUNT increments.
- Results are pushed to the FIFO except in mode 2.

## Timing
- Reset values:
  - All outputs are 0.
  - Registers are 0; state is IDLE; mode is 0; the FIFO is empty.
- Reset mid-run aborts immediately. No go pulse is emitted after reset is released.
- Start write in cycle t → LAUNCH in t+1, so go is high in cycle t+1 only. busy reads 1 from t+1.
- A word popped in cycle t is pushed to the FIFO at the end of cycle t+2. It is visible in STATUS fill and RESULT from t+3.
- CSR read in cycle t → readdatavalid=1 with data in t+1. Fixed latency, no waitrequest, back-to-back reads allowed.
- A RESULT read popping in the same cycle as a pipeline push leaves the fill count unchanged.
- If done is sampled in the same cycle as a pop, that word is still processed before DONE.

## Structure
- Package rbm_stream_pkg holds:
  - CSR address localparams
  - mode enum
  - state enum (IDLE, LAUNCH, RUN, DRAIN, DONE)
  - STATUS bit positions
- Sub-module rbm_result_fifo: synchronous FIFO with width and depth parameters.
  - Ports: push, pop, data, empty, count.
  - Pointers wrap at RESULT_DEPTH; count is $clog2(RESULT_DEPTH)+1 bits.

## Test plan
- Mode 1, BASE=0x1000, LENGTH=16, reader supplies 1,2,3,4 then done → one go pulse; RESULT reads return 2,4,6,8; ACCUM=10; WORDCOUNT=4; done=1.
- Mode 2, words 0xFFFFFFFF and 2 → no FIFO pushes (empty=1); ACCUM=1 (wrap).
- RESULT_DEPTH=4, reader supplies 10 words and software does not read → fill stalls at 4 and read_buffer=0. Draining RESULT resumes flow; all 10 values arrive in order.
- LENGTH=0 start → no go pulse; done=1 two cycles after start; WORDCOUNT=0.
- A second start write during RUN → ignored; BASE write during RUN → BASE readback unchanged.
- RESULT read when empty → returns 0, underflow=1. Assert reset mid-RUN → all outputs 0, state IDLE, FIFO empty.

Source files
------------

// File: rtl/rbm_stream_pkg.sv
// Shared constants for the RBM stream engine: CSR map, compute modes,
// controller states and STATUS register layout.
package rbm_stream_pkg;

   localparam logic [2:0] CSR_CONTROL   = 3'd0;
   localparam logic [2:0] CSR_BASE      = 3'd1;
   localparam logic [2:0] CSR_LENGTH    = 3'd2;
   localparam logic [2:0] CSR_STATUS    = 3'd3;
   localparam logic [2:0] CSR_RESULT    = 3'd4;
   localparam logic [2:0] CSR_ACCUM     = 3'd5;
   localparam logic [2:0] CSR_WORDCOUNT = 3'd6;

   typedef enum logic [1:0] {
      MODE_PASS   = 2'd0,
      MODE_DOUBLE = 2'd1,
      MODE_ACCUM  = 2'd2,
      MODE_PASS3  = 2'd3
   } mode_e;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_LAUNCH = 3'd1;
   localparam state_t ST_RUN    = 3'd2;
   localparam state_t ST_DRAIN  = 3'd3;
   localparam state_t ST_DONE   = 3'd4;

   localparam int STAT_BUSY      = 0;
   localparam int STAT_DONE      = 1;
   localparam int STAT_EMPTY     = 2;
   localparam int STAT_UNDERFLOW = 3;
   localparam int STAT_FILL_LSB  = 8;

endpackage

// File: rtl/rbm_result_fifo.sv
// Synchronous result FIFO; pops on empty are ignored, pushes are never
// issued when full because the producer reserves space up front.
module rbm_result_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clr,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       push_data,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_pop;

   assign empty    = (count_q == '0);
   assign do_pop   = pop && !empty;
   assign pop_data = mem_q[rd_ptr_q];
   assign count    = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/rbm_stream_engine.sv
// Avalon-MM control/compute engine: programs the memory reader, streams its
// FIFO through a 2-stage compute pipe and buffers results for CSR readout.
module rbm_stream_engine
   import rbm_stream_pkg::*;
#(
   parameter int DATAWIDTH     = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int RESULT_DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [2:0]               avs_s0_address,
   input  logic                     avs_s0_read,
   input  logic                     avs_s0_write,
   input  logic [ADDRESS_WIDTH-1:0] avs_s0_writedata,
   output logic [ADDRESS_WIDTH-1:0] avs_s0_readdata,
   output logic                     avs_s0_readdatavalid,
   output logic                     coe_control_fixed_location,
   output logic [ADDRESS_WIDTH-1:0] coe_control_read_base,
   output logic [ADDRESS_WIDTH-1:0] coe_control_read_length,
   output logic                     coe_control_go,
   input  logic                     coe_control_done,
   input  logic                     coe_control_early_done,
   input  logic [DATAWIDTH-1:0]     coe_user_buffer_data,
   input  logic                     coe_user_data_available,
   output logic                     coe_user_read_buffer
);
   localparam int CW = $clog2(RESULT_DEPTH) + 1;

   state_t                 state_q, state_d;
   mode_e                  mode_q, mode_d;
   logic [ADDRESS_WIDTH-1:0] base_q, base_d, length_q, length_d, wcount_q, wcount_d;
   logic [ADDRESS_WIDTH-1:0] rdata_q, rdata_d;
   logic [DATAWIDTH-1:0]   accum_q, accum_d, s1_data_q, s1_data_d, s2_data_q, s2_data_d;
   logic                   done_q, done_d, underflow_q, underflow_d, rvalid_q, rvalid_d;
   logic                   s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;

   logic                   busy, ctrl_wr, start_wr, result_rd, streaming, fifo_push, fifo_empty;
   logic [CW-1:0]          fifo_count;
   logic [CW:0]            occupancy;
   logic [DATAWIDTH-1:0]   s2_result, fifo_head;
   logic [15:0]            status;
   logic                   unused_ok;

   assign unused_ok = coe_control_early_done;

   assign busy      = (state_q != ST_IDLE);
   assign ctrl_wr   = avs_s0_write && (avs_s0_address == CSR_CONTROL) && !busy;
   assign start_wr  = ctrl_wr && avs_s0_writedata[0];
   assign result_rd = avs_s0_read && (avs_s0_address == CSR_RESULT);
   assign streaming = (state_q == ST_RUN) || (state_q == ST_DRAIN);

   // Space is reserved for every word already in the pipe, so pushes never overflow.
   assign occupancy = {1'b0, fifo_count} + (CW+1)'(s1_vld_q) + (CW+1)'(s2_vld_q);
   assign coe_user_read_buffer = coe_user_data_available && streaming &&
                                 (occupancy <= (CW+1)'(RESULT_DEPTH - 1));

   assign s2_result = (mode_q == MODE_DOUBLE) ? (s2_data_q << 1) : s2_data_q;
   assign fifo_push = s2_vld_q && (mode_q != MODE_ACCUM);

   assign coe_control_fixed_location = 1'b0;
   assign coe_control_read_base      = base_q;
   assign coe_control_read_length    = length_q;
   assign coe_control_go             = (state_q == ST_LAUNCH);
   assign avs_s0_readdata            = rdata_q;
   assign avs_s0_readdatavalid       = rvalid_q;

   rbm_result_fifo #(
      .WIDTH (DATAWIDTH),
      .DEPTH (RESULT_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clr       (start_wr),
      .push      (fifo_push),
      .pop       (result_rd),
      .push_data (s2_result),
      .pop_data  (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      base_d      = base_q;
      length_d    = length_q;
      done_d      = done_q;
      underflow_d = underflow_q;
      accum_d     = accum_q;
      wcount_d    = wcount_q;
      s1_vld_d    = coe_user_read_buffer;
      s1_data_d   = coe_user_read_buffer ? coe_user_buffer_data : s1_data_q;
      s2_vld_d    = s1_vld_q;
      s2_data_d   = s1_data_q;

      case (state_q)
         ST_IDLE:   if (start_wr) state_d = (length_q == '0) ? ST_DONE : ST_LAUNCH;
         ST_LAUNCH: state_d = ST_RUN;
         ST_RUN:    if (coe_control_done) state_d = ST_DRAIN;
         ST_DRAIN:  if (!coe_user_data_available && !s1_vld_q && !s2_vld_q) state_d = ST_DONE;
         ST_DONE: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
         default:   state_d = ST_IDLE;
      endcase

      if (ctrl_wr) mode_d = mode_e'(avs_s0_writedata[2:1]);
      if (avs_s0_write && !busy && avs_s0_address == CSR_BASE)   base_d   = avs_s0_writedata;
      if (avs_s0_write && !busy && avs_s0_address == CSR_LENGTH) length_d = avs_s0_writedata;

      if (s2_vld_q) begin
         accum_d  = accum_q + s2_data_q;
         wcount_d = wcount_q + ADDRESS_WIDTH'(1);
      end
      if (result_rd && fifo_empty) underflow_d = 1'b1;

      if (start_wr) begin
         done_d      = 1'b0;
         underflow_d = 1'b0;
         accum_d     = '0;
         wcount_d    = '0;
      end
   end

   always_comb begin
      status                   = '0;
      status[STAT_BUSY]        = busy;
      status[STAT_DONE]        = done_q;
      status[STAT_EMPTY]       = fifo_empty;
      status[STAT_UNDERFLOW]   = underflow_q;
      status[STAT_FILL_LSB +: 8] = 8'(fifo_count);

      rdata_d  = '0;
      rvalid_d = avs_s0_read;
      if (avs_s0_read) begin
         case (avs_s0_address)
            CSR_CONTROL:   rdata_d = ADDRESS_WIDTH'(mode_q);
            CSR_BASE:      rdata_d = base_q;
            CSR_LENGTH:    rdata_d = length_q;
            CSR_STATUS:    rdata_d = ADDRESS_WIDTH'(status);
            CSR_RESULT:    rdata_d = fifo_empty ? '0 : ADDRESS_WIDTH'(fifo_head);
            CSR_ACCUM:     rdata_d = ADDRESS_WIDTH'(accum_q);
            CSR_WORDCOUNT: rdata_d = wcount_q;
            default:       rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_PASS;
         base_q      <= '0;
         length_q    <= '0;
         wcount_q    <= '0;
         accum_q     <= '0;
         done_q      <= 1'b0;
         underflow_q <= 1'b0;
         s1_vld_q    <= 1'b0;
         s2_vld_q    <= 1'b0;
         s1_data_q   <= '0;
         s2_data_q   <= '0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         base_q      <= base_d;
         length_q    <= length_d;
         wcount_q    <= wcount_d;
         accum_q     <= accum_d;
         done_q      <= done_d;
         underflow_q <= underflow_d;
         s1_vld_q    <= s1_vld_d;
         s2_vld_q    <= s2_vld_d;
         s1_data_q   <= s1_data_d;
         s2_data_q   <= s2_data_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
      end
   end

endmodule

// File: tb/tb_rbm_stream_engine.sv
// Bench for rbm_stream_engine: a reader model feeds random words, a
// transaction-level model predicts results, ACCUM and WORDCOUNT.
module tb_rbm_stream_engine;
   import rbm_stream_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  avs_s0_address;
   logic        avs_s0_read, avs_s0_write;
   logic [31:0] avs_s0_writedata, avs_s0_readdata;
   logic        avs_s0_readdatavalid;
   logic        coe_control_fixed_location, coe_control_go, coe_control_done, coe_control_early_done;
   logic [31:0] coe_control_read_base, coe_control_read_length, coe_user_buffer_data;
   logic        coe_user_data_available, coe_user_read_buffer;

   int          n_chk = 0, n_fail = 0, go_cnt = 0, go_base = 0, max_out = 0;
   logic [31:0] src_q[$], exp_q[$];
   logic [1:0]  mode_m = 2'd0;
   logic [31:0] acc_m = 32'd0, wc_m = 32'd0;
   logic        pend_pop = 1'b0;

   always #5 clk = ~clk;

   rbm_stream_engine #(.DATAWIDTH(32), .ADDRESS_WIDTH(32), .RESULT_DEPTH(DEPTH)) dut (
      .clk                        (clk),
      .reset                      (reset),
      .avs_s0_address             (avs_s0_address),
      .avs_s0_read                (avs_s0_read),
      .avs_s0_write               (avs_s0_write),
      .avs_s0_writedata           (avs_s0_writedata),
      .avs_s0_readdata            (avs_s0_readdata),
      .avs_s0_readdatavalid       (avs_s0_readdatavalid),
      .coe_control_fixed_location (coe_control_fixed_location),
      .coe_control_read_base      (coe_control_read_base),
      .coe_control_read_length    (coe_control_read_length),
      .coe_control_go             (coe_control_go),
      .coe_control_done           (coe_control_done),
      .coe_control_early_done     (coe_control_early_done),
      .coe_user_buffer_data       (coe_user_buffer_data),
      .coe_user_data_available    (coe_user_data_available),
      .coe_user_read_buffer       (coe_user_read_buffer)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Every word the engine takes contributes to the sum and count; results are kept in order.
   function automatic void consume(input logic [31:0] w);
      acc_m = acc_m + w;
      wc_m  = wc_m + 32'd1;
      if (mode_m != 2'd2) exp_q.push_back(mode_m == 2'd1 ? w * 2 : w);
   endfunction

   // Reader FIFO model: head stays stable for a whole cycle, popped when read_buffer was high.
   initial begin
      coe_user_data_available = 1'b0;
      coe_user_buffer_data    = 32'd0;
      forever begin
         @(negedge clk);
         if (pend_pop && src_q.size() > 0) consume(src_q.pop_front());
         coe_user_data_available = (src_q.size() > 0);
         coe_user_buffer_data    = (src_q.size() > 0) ? src_q[0] : 32'd0;
         #1 pend_pop = coe_user_read_buffer;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (coe_control_go) go_cnt++;
         if (exp_q.size() > max_out) max_out = exp_q.size();
      end
   end

   task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
      avs_s0_address   = a;
      avs_s0_writedata = d;
      avs_s0_write     = 1'b1;
      @(negedge clk);
      avs_s0_write     = 1'b0;
   endtask

   task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
      avs_s0_address = a;
      avs_s0_read    = 1'b1;
      @(negedge clk);
      avs_s0_read    = 1'b0;
      chk("readdatavalid", avs_s0_readdatavalid, 1'b1);
      d = avs_s0_readdata;
   endtask

   task automatic load_words(input int n);
      for (int i = 0; i < n; i++)
         src_q.push_back(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
   endtask

   task automatic start_job(input logic [1:0] mode);
      logic [31:0] st;
      mode_m  = mode;
      acc_m   = 32'd0;
      wc_m    = 32'd0;
      exp_q.delete();
      go_base = go_cnt;
      csr_write(CSR_CONTROL, {29'd0, mode, 1'b1});
      chk("go_after_start", coe_control_go, 1'b1);
      @(negedge clk);
      chk("go_one_cycle", coe_control_go, 1'b0);
      csr_read(CSR_STATUS, st);
      chk("busy_after_start", st[0], 1'b1);
      chk("underflow_cleared", st[3], 1'b0);
   endtask

   task automatic finish_job(input int done_at);
      logic [31:0] st, d;
      bit done_sent = 0;
      int guard = 0;
      while (guard < 2000) begin
         guard++;
         if (!done_sent && src_q.size() <= done_at) begin
            coe_control_done = 1'b1;
            @(negedge clk);
            coe_control_done = 1'b0;
            done_sent = 1;
         end
         csr_read(CSR_STATUS, st);
         if (st[15:8] != 8'd0) begin
            csr_read(CSR_RESULT, d);
            if (exp_q.size() > 0) chk("result", d, exp_q.pop_front());
            else chk("result_extra", exp_q.size(), 1);
         end
         if (done_sent && !st[0] && st[15:8] == 8'd0) break;
      end
      chk("job_in_budget", guard < 2000, 1'b1);
      chk("results_all_seen", exp_q.size(), 0);
      chk("src_all_taken", src_q.size(), 0);
      csr_read(CSR_ACCUM, d);
      chk("accum", d, acc_m);
      csr_read(CSR_WORDCOUNT, d);
      chk("wordcount", d, wc_m);
      csr_read(CSR_STATUS, st);
      chk("status_end", {st[3:0]}, 4'b0110);
      chk("go_pulses", go_cnt - go_base, 1);
   endtask

   initial begin
      logic [31:0] d, st;
      int g;
      reset = 1'b1;
      avs_s0_address = 3'd0; avs_s0_read = 1'b0; avs_s0_write = 1'b0; avs_s0_writedata = 32'd0;
      coe_control_done = 1'b0; coe_control_early_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_go", coe_control_go, 1'b0);
      chk("rst_read_buffer", coe_user_read_buffer, 1'b0);
      chk("rst_rdvalid", avs_s0_readdatavalid, 1'b0);
      chk("rst_readdata", avs_s0_readdata, 32'd0);
      chk("rst_base", coe_control_read_base, 32'd0);
      chk("rst_length", coe_control_read_length, 32'd0);
      chk("rst_fixed", coe_control_fixed_location, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      csr_read(CSR_STATUS, d);    chk("status_rst", d, 32'h4);
      csr_read(CSR_CONTROL, d);   chk("mode_rst", d, 32'd0);
      csr_read(CSR_ACCUM, d);     chk("accum_rst", d, 32'd0);
      csr_read(3'd7, d);          chk("addr7", d, 32'd0);

      // Mode 1 with the fixed 1..4 sequence
      csr_write(CSR_BASE, 32'h1000);
      csr_write(CSR_LENGTH, 32'd16);
      csr_read(CSR_BASE, d);      chk("base_rb", d, 32'h1000);
      csr_read(CSR_LENGTH, d);    chk("length_rb", d, 32'd16);
      chk("base_port", coe_control_read_base, 32'h1000);
      chk("length_port", coe_control_read_length, 32'd16);
      for (int i = 1; i <= 4; i++) src_q.push_back(i);
      start_job(2'd1);
      csr_read(CSR_CONTROL, d);   chk("mode_rb", d, 32'd1);
      finish_job(0);
      csr_read(CSR_ACCUM, d);     chk("t1_accum", d, 32'd10);
      csr_read(CSR_WORDCOUNT, d); chk("t1_wordcount", d, 32'd4);

      // Accumulate-only with wraparound
      src_q.push_back(32'hFFFF_FFFF);
      src_q.push_back(32'd2);
      start_job(2'd2);
      finish_job(0);
      csr_read(CSR_ACCUM, d);     chk("t2_accum_wrap", d, 32'd1);

      // Zero length: no launch, done two cycles after the start write
      csr_write(CSR_LENGTH, 32'd0);
      g = go_cnt;
      csr_write(CSR_CONTROL, 32'd1);
      csr_read(CSR_STATUS, st);   chk("len0_t1", st[1:0], 2'b01);
      csr_read(CSR_STATUS, st);   chk("len0_t2", st[1:0], 2'b10);
      csr_read(CSR_WORDCOUNT, d); chk("len0_wordcount", d, 32'd0);
      csr_read(CSR_ACCUM, d);     chk("len0_accum_clr", d, 32'd0);
      chk("len0_no_go", go_cnt - g, 0);

      // Underflow
      csr_read(CSR_RESULT, d);    chk("underflow_data", d, 32'd0);
      csr_read(CSR_STATUS, st);   chk("underflow_flag", st[3], 1'b1);

      // Backpressure: ten words, nobody reading
      csr_write(CSR_LENGTH, 32'd40);
      load_words(10);
      start_job(2'd0);
      repeat (30) @(negedge clk);
      csr_read(CSR_STATUS, st);   chk("stall_fill", st[15:8], 8'd4);
      chk("stall_read_buffer", coe_user_read_buffer, 1'b0);
      chk("stall_src_left", src_q.size(), 6);
      finish_job(0);

      // Writes while busy are ignored
      csr_write(CSR_BASE, 32'h2000);
      load_words(3);
      start_job(2'd0);
      csr_write(CSR_BASE, 32'h3333);
      csr_write(CSR_LENGTH, 32'd5);
      csr_write(CSR_CONTROL, 32'd3);
      csr_read(CSR_BASE, d);      chk("busy_base", d, 32'h2000);
      csr_read(CSR_LENGTH, d);    chk("busy_length", d, 32'd40);
      csr_read(CSR_CONTROL, d);   chk("busy_mode", d, 32'd0);
      finish_job(0);

      // Random jobs
      for (int j = 0; j < 6; j++) begin
         load_words($urandom_range(1, 9));
         start_job(2'($urandom_range(0, 3)));
         finish_job($urandom_range(0, 2));
      end

      // Reset in the middle of a run
      load_words(10);
      start_job(2'd1);
      repeat (6) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_go", coe_control_go, 1'b0);
      chk("mid_rst_read_buffer", coe_user_read_buffer, 1'b0);
      chk("mid_rst_readdata", avs_s0_readdata, 32'd0);
      chk("mid_rst_base", coe_control_read_base, 32'd0);
      chk("mid_rst_length", coe_control_read_length, 32'd0);
      src_q.delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      g = go_cnt;
      repeat (5) @(negedge clk);
      chk("post_rst_no_go", go_cnt - g, 0);
      csr_read(CSR_STATUS, d);    chk("post_rst_status", d, 32'h4);
      csr_read(CSR_WORDCOUNT, d); chk("post_rst_wordcount", d, 32'd0);

      chk("max_outstanding", max_out <= DEPTH, 1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
